// File: rtl/csa_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csa_seq_pkg
//  Purpose  : Shared definitions for the sequential carry-select adder:
//             slice width, sequencer state encoding, counter width helper.
//  Revision : 1.0  initial release
// ============================================================================
package csa_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the slice-pass counter; at least one bit even for one pass
    function automatic int cnt_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa.sv
`default_nettype none
// ============================================================================
//  Module   : csa
//  Purpose  : 4-bit carry-select adder slice. Both carry-in outcomes are
//             precomputed and the incoming carry only drives the final mux.
//  Revision : 1.0  initial release
// ============================================================================
module csa
    import csa_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] w_sum_c0;
    logic [SLICE_W:0] w_sum_c1;

    // Precompute both candidate results, then select with the incoming carry
    always_comb begin
        w_sum_c0 = {1'b0, a} + {1'b0, b};
        w_sum_c1 = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, 1'b1};
        if (cin) begin
            sum  = w_sum_c1[SLICE_W-1:0];
            cout = w_sum_c1[SLICE_W];
        end else begin
            sum  = w_sum_c0[SLICE_W-1:0];
            cout = w_sum_c0[SLICE_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/csa_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : csa_seq_adder
//  Purpose  : WIDTH-bit adder built from one 4-bit carry-select slice reused
//             once per cycle, LSB nibble first, with valid/ready handshakes
//             on operands and result.
//  Options  : CSA_SEQ_SUB_EN - adds the sub port; sub=1 computes a-b.
//  Revision : 1.0  initial release
// ============================================================================
module csa_seq_adder
    import csa_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NSLICE - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;

    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_load;

    // Operand B and initial carry as captured on acceptance
`ifdef CSA_SEQ_SUB_EN
    always_comb begin
        w_b_load     = sub ? ~b : b;
        w_carry_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        w_b_load     = b;
        w_carry_load = cin;
    end
`endif

    csa u_csa (
        .a    (r_a_sh[SLICE_W-1:0]),
        .b    (r_b_sh[SLICE_W-1:0]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Sequencer: accept, run NSLICE slice passes, then hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_carry_load;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh  <= r_a_sh >> SLICE_W;
                    r_b_sh  <= r_b_sh >> SLICE_W;
                    r_sum   <= {w_slice_sum, r_sum[WIDTH-1:SLICE_W]};
                    r_carry <= w_slice_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == C_LAST_CNT) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake and status outputs decode registered state only
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
        sum       = r_sum;
        cout      = r_carry;
    end

endmodule
`default_nettype wire

// File: doc/csa_seq_adder.md
# csa_seq_adder

Multi-cycle sequencer that performs a WIDTH-bit addition by running one 4-bit carry-select slice once per cycle, least-significant nibble first. The carry is registered between slices. Operands enter through a valid/ready input handshake and the result leaves through a valid/ready output handshake. It sits between operand producers and consumers wherever a wide add is needed but only one 4-bit carry-select slice is affordable.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- NSLICE, WIDTH/4, derived, not overridable; number of slice passes

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry into slice 0
- sub  in  1  subtract request; present only with CSA_SEQ_SUB_EN
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of top slice
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b and cin into a_sh, b_sh and carry_q; slice counter cnt=0; go to RUN.
- RUN:
  - in_ready=0.
  - Slice inputs are a_sh[3:0], b_sh[3:0] and carry_q.
  - Each edge: a_sh and b_sh shift right 4; slice sum shifts into sum_q at the MSB nibble; carry_q takes the slice cout; cnt increments.
  - When cnt==NSLICE-1 at the edge: go to DONE.
- DONE:
  - out_valid=1; sum=sum_q, cout=carry_q, both held stable.
  - On out_ready: go to IDLE.
  - out_valid is never withdrawn before out_ready.
- in_valid outside IDLE is ignored; the producer must hold its operands until in_ready.
- Arithmetic: unsigned modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1. No overflow flag.
- sum and cout are valid only while out_valid=1. They keep their last values in IDLE.
- Reset values: state=IDLE, cnt=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1 (decoded from state).
- Reset mid-operation: aborts immediately; no result is produced; the next accepted operation is unaffected.

## Timing
- Accept at edge k. RUN covers edges k+1 … k+NSLICE. out_valid goes high after edge k+NSLICE. Latency is NSLICE cycles (4 for WIDTH=16).
- With out_ready=1 in DONE: back to IDLE after edge k+NSLICE+1. in_ready is high for the following cycle.
- Minimum initiation interval: NSLICE+2 cycles.
- in_ready and out_valid are decoded from registered state only, with no combinational path from the inputs.
- Slice timing: one 4-bit carry-select delay plus the mux on carry_q per cycle.

## Configuration
- CSA_SEQ_SUB_EN defined:
  - The sub port exists. When sub=1 at acceptance, b_sh captures ~b and carry_q captures 1; cin is ignored.
  - The result is a−b mod 2^WIDTH. cout=1 means no borrow (a≥b unsigned).
  - sub=0 behaves exactly like plain add.
- CSA_SEQ_SUB_EN undefined: the sub port and the inversion logic are absent; add only.

## Structure
- Package csa_seq_pkg holds:
  - SLICE_W=4.
  - The state enum (IDLE, RUN, DONE).
  - A function returning the counter width, clog2(NSLICE).
- One sub-module: a single instance of the existing 4-bit carry-select slice, csa. All sequencing, shifting and the handshakes live in csa_seq_adder.

## Test plan
All scenarios use WIDTH=16.
- 0x1234+0x4321, cin=0, out_ready=1 → sum=0x5555, cout=0; out_valid exactly 4 cycles after acceptance, high for 1 cycle.
- 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1. Then 0xFFFF+0x0000, cin=1 → sum=0x0000, cout=1. Checks carry passing through every slice.
- Backpressure: result 0x8000+0x8000 with out_ready=0 for 5 cycles → sum=0x0000 and cout=1 held stable, out_valid=1, in_ready=0. A new in_valid in this window is ignored. out_ready=1 → IDLE one edge later.
- Back-to-back: in_valid held high with two operand pairs and out_ready=1 → both results correct, second acceptance NSLICE+2 cycles after the first.
- Reset asserted after 2 RUN edges of 0x00FF+0x0001 → sum=0, cout=0, out_valid=0, in_ready=1. After release, 0x0100+0x0100 → 0x0200, cout=0.
- With CSA_SEQ_SUB_EN:
  - 0x0005−0x0007 → 0xFFFE, cout=0.
  - 0x0007−0x0005 → 0x0002, cout=1.
  - sub=1 with cin=0 gives the same results.
